// File: rtl/debug_pkg.sv
// Shared definitions for the debug serial blocks: parameter defaults, the
// receiver state encoding and the frame counter width.
package debug_pkg;

  localparam int unsigned DefaultWidth     = 40;
  localparam bit          DefaultLsbFirst  = 1'b0;
  localparam bit          DefaultParityEn  = 1'b0;
  localparam bit          DefaultParityOdd = 1'b0;

  localparam int unsigned FrameCountWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity,
    StLoad
  } rx_state_e;

endpackage

// File: rtl/debug_hold_reg.sv
// Output holding register with a valid/ready handshake, a sticky overrun flag
// and a wrapping count of accepted frames.
module debug_hold_reg
  import debug_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                       debug_clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       load_perr,
  input  logic                       out_ready,
  input  logic                       status_clr,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  output logic                       parity_err,
  output logic                       overrun,
  output logic [FrameCountWidth-1:0] frame_count
);

  logic [WIDTH-1:0]           data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       perr_q, perr_d;
  logic                       overrun_q, overrun_d;
  logic [FrameCountWidth-1:0] count_q, count_d;
  logic                       accept, drop;

  // A new frame is taken if the slot is empty or being drained on the same edge.
  assign accept = load & (~valid_q | out_ready);
  assign drop   = load & valid_q & ~out_ready;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    overrun_d = overrun_q;
    count_d   = count_q;
    if (accept) begin
      data_d  = load_data;
      valid_d = 1'b1;
      perr_d  = load_perr;
      count_d = count_q + FrameCountWidth'(1);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    // A drop on the clearing edge must remain visible.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (status_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge debug_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  assign data_out    = data_q;
  assign out_valid   = valid_q;
  assign parity_err  = perr_q;
  assign overrun     = overrun_q;
  assign frame_count = count_q;

endmodule

// File: rtl/debug_frame_receiver.sv
// Serial debug frame receiver: start strobe, WIDTH data bits, optional parity
// bit, then a single load cycle into the handshaked output holding register.
module debug_frame_receiver
  import debug_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter bit          LSB_FIRST  = DefaultLsbFirst,
  parameter bit          PARITY_EN  = DefaultParityEn,
  parameter bit          PARITY_ODD = DefaultParityOdd
) (
  input  logic                       debug_clk,
  input  logic                       reset_n,
  input  logic                       data_start,
  input  logic                       sin,
  input  logic                       out_ready,
  input  logic                       status_clr,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  output logic                       parity_err,
  output logic                       overrun,
  output logic [FrameCountWidth-1:0] frame_count,
  output logic                       busy
);

  localparam int unsigned CntWidth = $clog2(WIDTH + 1);

  rx_state_e           state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic                par_bit_q, par_bit_d;
  logic                frame_perr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    unique case (state_q)
      StIdle: begin
        if (data_start) begin
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // The edge after the last sample only advances the FSM.
        if (cnt_q == CntWidth'(WIDTH)) begin
          state_d = PARITY_EN ? StParity : StLoad;
        end else begin
          cnt_d   = cnt_q + CntWidth'(1);
          shift_d = LSB_FIRST ? {sin, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], sin};
        end
      end
      StParity: begin
        par_bit_d = sin;
        state_d   = StLoad;
      end
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge debug_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Error when data+parity ones count is odd (even mode) or even (odd mode).
  assign frame_perr = PARITY_EN & ((^shift_q) ^ par_bit_q ^ PARITY_ODD);
  assign busy       = (state_q != StIdle);

  debug_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .debug_clk  (debug_clk),
    .reset_n    (reset_n),
    .load       (state_q == StLoad),
    .load_data  (shift_q),
    .load_perr  (frame_perr),
    .out_ready  (out_ready),
    .status_clr (status_clr),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .parity_err (parity_err),
    .overrun    (overrun),
    .frame_count(frame_count)
  );

endmodule

// File: tb/tb_debug_frame_receiver.sv
// Directed bench for debug_frame_receiver: three instances (40-bit MSB-first,
// 8-bit LSB-first with even parity, 8-bit MSB-first) share the input pins.
module tb_debug_frame_receiver;

  logic debug_clk  = 1'b0;
  logic reset_n    = 1'b1;
  logic data_start = 1'b0;
  logic sin        = 1'b0;
  logic out_ready  = 1'b0;
  logic status_clr = 1'b0;

  logic [39:0] d40;
  logic        v40, pe40, ov40, b40;
  logic [7:0]  fc40;
  logic [7:0]  dp;
  logic        vp, pep, ovp, bp;
  logic [7:0]  fcp;
  logic [7:0]  dm;
  logic        vm, pem, ovm, bm;
  logic [7:0]  fcm;

  int vectors     = 0;
  int miscompares = 0;

  always #5 debug_clk = ~debug_clk;

  debug_frame_receiver #(
    .WIDTH(40), .LSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) u_dut40 (
    .debug_clk(debug_clk), .reset_n(reset_n), .data_start(data_start), .sin(sin),
    .out_ready(out_ready), .status_clr(status_clr), .data_out(d40), .out_valid(v40),
    .parity_err(pe40), .overrun(ov40), .frame_count(fc40), .busy(b40)
  );

  debug_frame_receiver #(
    .WIDTH(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) u_dut8p (
    .debug_clk(debug_clk), .reset_n(reset_n), .data_start(data_start), .sin(sin),
    .out_ready(out_ready), .status_clr(status_clr), .data_out(dp), .out_valid(vp),
    .parity_err(pep), .overrun(ovp), .frame_count(fcp), .busy(bp)
  );

  debug_frame_receiver #(
    .WIDTH(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) u_dut8 (
    .debug_clk(debug_clk), .reset_n(reset_n), .data_start(data_start), .sin(sin),
    .out_ready(out_ready), .status_clr(status_clr), .data_out(dm), .out_valid(vm),
    .parity_err(pem), .overrun(ovm), .frame_count(fcm), .busy(bm)
  );

  task automatic tick();
    @(posedge debug_clk);
    #1;
  endtask

  task automatic apply_reset();
    data_start = 1'b0;
    sin        = 1'b0;
    out_ready  = 1'b0;
    status_clr = 1'b0;
    reset_n    = 1'b0;
    #3;
    tick();
    reset_n = 1'b1;
  endtask

  // Start edge, w data edges, FSM-advance edge, optional parity edge, LOAD edge.
  task automatic send(input logic [63:0] val, input int w, input bit lsb, input bit par_en,
                      input bit par_bit, input bit ready_load, input bit clr_load,
                      input int glitch);
    data_start = 1'b1;
    tick();
    data_start = 1'b0;
    for (int i = 0; i < w; i++) begin
      sin        = lsb ? val[i] : val[w-1-i];
      data_start = (i == glitch);
      tick();
    end
    data_start = 1'b0;
    sin        = 1'b0;
    tick();
    if (par_en) begin
      sin = par_bit;
      tick();
      sin = 1'b0;
    end
    out_ready  = ready_load;
    status_clr = clr_load;
    tick();
    status_clr = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (d40 !== 40'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", d40); end
    vectors++; if (v40 !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", v40); end
    vectors++; if (fc40 !== 8'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", fc40); end
    vectors++; if (ov40 !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", ov40); end
    vectors++; if (b40 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", b40); end
    vectors++; if (pep !== 1'b0) begin miscompares++; $display("FAIL reset_perr got %b want 0", pep); end
    apply_reset();
  endtask

  task automatic test_msb40();
    logic [39:0] val;
    val = 40'hA5_1234_5678;
    apply_reset();
    out_ready  = 1'b1;
    data_start = 1'b1;
    tick();
    data_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sin = val[39-i];
      tick();
    end
    sin = 1'b0;
    tick();  // edge 41
    vectors++; if (v40 !== 1'b0) begin miscompares++; $display("FAIL msb40_early_valid got %b want 0", v40); end
    vectors++; if (b40 !== 1'b1) begin miscompares++; $display("FAIL msb40_busy got %b want 1", b40); end
    tick();  // edge 42
    vectors++; if (v40 !== 1'b1) begin miscompares++; $display("FAIL msb40_valid got %b want 1", v40); end
    vectors++; if (d40 !== 40'hA512345678) begin miscompares++; $display("FAIL msb40_data got %h want a512345678", d40); end
    vectors++; if (fc40 !== 8'd1) begin miscompares++; $display("FAIL msb40_count got %0d want 1", fc40); end
    vectors++; if (b40 !== 1'b0) begin miscompares++; $display("FAIL msb40_idle got %b want 0", b40); end
    vectors++; if (pe40 !== 1'b0) begin miscompares++; $display("FAIL msb40_perr got %b want 0", pe40); end
    tick();
    vectors++; if (v40 !== 1'b0) begin miscompares++; $display("FAIL msb40_drain got %b want 0", v40); end
    vectors++; if (d40 !== 40'hA512345678) begin miscompares++; $display("FAIL msb40_keep got %h want a512345678", d40); end
  endtask

  task automatic test_parity();
    apply_reset();
    out_ready = 1'b1;
    send(64'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    vectors++; if (dp !== 8'h3C) begin miscompares++; $display("FAIL par_data0 got %h want 3c", dp); end
    vectors++; if (vp !== 1'b1) begin miscompares++; $display("FAIL par_valid0 got %b want 1", vp); end
    vectors++; if (pep !== 1'b0) begin miscompares++; $display("FAIL par_ok got %b want 0", pep); end
    send(64'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    vectors++; if (pep !== 1'b1) begin miscompares++; $display("FAIL par_err got %b want 1", pep); end
    vectors++; if (fcp !== 8'd2) begin miscompares++; $display("FAIL par_count got %0d want 2", fcp); end
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    vectors++; if (pep !== 1'b1) begin miscompares++; $display("FAIL par_clr_keep got %b want 1", pep); end
    send(64'h12, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    vectors++; if (dp !== 8'h12) begin miscompares++; $display("FAIL par_lsb_order got %h want 12", dp); end
    vectors++; if (pep !== 1'b0) begin miscompares++; $display("FAIL par_ok2 got %b want 0", pep); end
  endtask

  task automatic test_overrun();
    apply_reset();
    send(64'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    vectors++; if (dm !== 8'h11) begin miscompares++; $display("FAIL ovr_first got %h want 11", dm); end
    vectors++; if (ovm !== 1'b0) begin miscompares++; $display("FAIL ovr_none got %b want 0", ovm); end
    send(64'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    vectors++; if (dm !== 8'h11) begin miscompares++; $display("FAIL ovr_hold got %h want 11", dm); end
    vectors++; if (ovm !== 1'b1) begin miscompares++; $display("FAIL ovr_set got %b want 1", ovm); end
    vectors++; if (fcm !== 8'd1) begin miscompares++; $display("FAIL ovr_count got %0d want 1", fcm); end
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    vectors++; if (ovm !== 1'b0) begin miscompares++; $display("FAIL ovr_clr got %b want 0", ovm); end
    vectors++; if (vm !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got %b want 1", vm); end
    send(64'h33, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    vectors++; if (ovm !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins got %b want 1", ovm); end
    vectors++; if (dm !== 8'h11) begin miscompares++; $display("FAIL ovr_hold2 got %h want 11", dm); end
  endtask

  task automatic test_reset_mid();
    int seen;
    apply_reset();
    send(64'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    data_start = 1'b1;
    tick();
    data_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin = i[0];
      tick();
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (dm !== 8'h00) begin miscompares++; $display("FAIL rmid_data got %h want 00", dm); end
    vectors++; if (vm !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got %b want 0", vm); end
    vectors++; if (fcm !== 8'd0) begin miscompares++; $display("FAIL rmid_count got %0d want 0", fcm); end
    vectors++; if (bm !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", bm); end
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (vm !== 1'b0 || bm !== 1'b0) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rmid_quiet got %0d want 0", seen); end
    out_ready = 1'b1;
    send(64'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    vectors++; if (dm !== 8'h5A) begin miscompares++; $display("FAIL rmid_after got %h want 5a", dm); end
    vectors++; if (fcm !== 8'd1) begin miscompares++; $display("FAIL rmid_count2 got %0d want 1", fcm); end
  endtask

  task automatic test_restart_and_wrap();
    apply_reset();
    out_ready = 1'b1;
    send(64'hB4, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    vectors++; if (dm !== 8'hB4) begin miscompares++; $display("FAIL restart_data got %h want b4", dm); end
    vectors++; if (fcm !== 8'd1) begin miscompares++; $display("FAIL restart_count got %0d want 1", fcm); end
    for (int k = 0; k < 254; k++) send(64'(k), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    vectors++; if (fcm !== 8'd255) begin miscompares++; $display("FAIL wrap_255 got %0d want 255", fcm); end
    vectors++; if (dm !== 8'hFD) begin miscompares++; $display("FAIL wrap_data got %h want fd", dm); end
    send(64'h9E, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    vectors++; if (fcm !== 8'd0) begin miscompares++; $display("FAIL wrap_zero got %0d want 0", fcm); end
    vectors++; if (vm !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got %b want 1", vm); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send(64'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    vectors++; if (dm !== 8'h0F) begin miscompares++; $display("FAIL b2b_first got %h want 0f", dm); end
    send(64'hF0, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    vectors++; if (dm !== 8'hF0) begin miscompares++; $display("FAIL b2b_data got %h want f0", dm); end
    vectors++; if (vm !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b want 1", vm); end
    vectors++; if (ovm !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun got %b want 0", ovm); end
    vectors++; if (fcm !== 8'd2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", fcm); end
    tick();
    vectors++; if (vm !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", vm); end
  endtask

  initial begin
    test_reset();
    test_msb40();
    test_parity();
    test_overrun();
    test_reset_mid();
    test_restart_and_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/debug_frame_receiver.md
DEBUG_FRAME_RECEIVER -- requirements
Module: debug_frame_receiver

Interface
REQ-001 Parameter WIDTH, default 40: data bits per frame, legal range 2..64.
REQ-002 Parameter LSB_FIRST, default 0: 0 means the first received bit ends in data_out[WIDTH-1]; 1 means the first received bit ends in data_out[0].
REQ-003 Parameter PARITY_EN, default 0: 1 means one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 means even parity, 1 means odd parity; ignored when PARITY_EN=0.
REQ-005 The block SHALL have one clock, debug_clk; all state SHALL update on the rising edge.
REQ-006 The block SHALL have reset_n, an asynchronous, active-low reset.
REQ-007 Ports (name, direction, width, meaning):
- debug_clk, in, 1: clock.
- reset_n, in, 1: asynchronous active-low reset.
- data_start, in, 1: frame start strobe.
- sin, in, 1: serial data.
- out_ready, in, 1: consumer accepts the held frame.
- status_clr, in, 1: clears the sticky flags.
- data_out, out, WIDTH: received frame.
- out_valid, out, 1: data_out holds an unconsumed frame.
- parity_err, out, 1: parity result of the held frame.
- overrun, out, 1: sticky dropped-frame flag.
- frame_count, out, 8: count of accepted frames.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, SHIFT, PARITY and LOAD.
REQ-011 In IDLE, data_start=1 SHALL clear the bit counter and move the FSM to SHIFT; sin is not sampled on that edge.
REQ-012 In SHIFT, the block SHALL sample sin on each of the next WIDTH edges into the shift register, packed in the order set by LSB_FIRST.
REQ-013 After the WIDTH-th sample, the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to LOAD.
REQ-014 PARITY SHALL last one edge, sample sin as the parity bit, and then go to LOAD.
REQ-015 LOAD SHALL last one edge and SHALL always return to IDLE.
REQ-016 On the LOAD edge, if out_valid=0 or out_ready=1, the block SHALL:
- copy the shift register to data_out;
- set out_valid=1;
- update parity_err;
- increment frame_count, wrapping 255 to 0.
REQ-017 On the LOAD edge, if out_valid=1 and out_ready=0, the block SHALL drop the new frame, set overrun=1, and leave data_out, parity_err and frame_count unchanged.
REQ-018 parity_err SHALL be 1 when the XOR of all data bits and the parity bit equals PARITY_ODD xor 1 (even mode errors on odd ones count, odd mode errors on even ones count); it SHALL always be 0 when PARITY_EN=0.
REQ-019 Latency: out_valid SHALL rise after edge WIDTH+2 counted from the data_start edge (edge 0) when PARITY_EN=0, and after edge WIDTH+3 when PARITY_EN=1.
REQ-020 out_valid=1 with out_ready=1 outside a LOAD edge SHALL clear out_valid on that edge.
REQ-021 A LOAD edge with out_ready=1 SHALL keep out_valid=1 and present the new frame (back-to-back transfer).
REQ-022 data_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 data_start outside IDLE SHALL be ignored; a frame is never restarted mid-reception.
REQ-024 data_start held high through LOAD SHALL start a new frame on the first IDLE edge.
REQ-025 status_clr=1 SHALL clear overrun; if a drop occurs on the same edge, the set SHALL win.
REQ-026 status_clr SHALL NOT affect parity_err, which follows the held frame.
REQ-027 busy SHALL be combinationally high whenever the state is not IDLE.

Reset
REQ-030 On reset_n=0, the block SHALL immediately force the FSM to IDLE and clear:
- the bit counter and the shift register;
- data_out, out_valid, parity_err, overrun and frame_count.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; no out_valid pulse SHALL follow reset release.
REQ-032 All flops SHALL be in the asynchronous reset domain of reset_n; there SHALL be no other reset.

Structure
REQ-040 The FSM state encoding and the frame_count width constant SHALL live in the shared package debug_pkg.
REQ-041 The parameter defaults SHALL be localparams in debug_pkg, so other debug blocks share the same defaults.
REQ-042 The output holding register and its handshake (REQ-016, REQ-017, REQ-020, REQ-021, REQ-022) SHALL be one sub-module, debug_hold_reg, parametrised by WIDTH.
REQ-043 The bit counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-050 WIDTH=40, LSB_FIRST=0, PARITY_EN=0: send 0xA5_1234_5678 MSB-first with out_ready=1 -> data_out=0xA51234_5678, out_valid rises after edge 42, frame_count=1.
REQ-051 WIDTH=8, LSB_FIRST=1, PARITY_EN=1, even: send 0x3C with parity 0 -> data_out=0x3C, parity_err=0; repeat with parity 1 -> parity_err=1.
REQ-052 WIDTH=8, out_ready=0: send 0x11 then 0x22 -> data_out stays 0x11, overrun=1, frame_count=1; pulse status_clr -> overrun=0.
REQ-053 WIDTH=8: pull reset_n low at bit 4 of a frame -> all outputs 0 immediately; a full frame after release is received correctly.
REQ-054 WIDTH=8: pulse data_start again during SHIFT -> ignored, frame completes unchanged; 256 accepted frames -> frame_count wraps to 0.
REQ-055 WIDTH=8: out_ready=1 on the LOAD edge while out_valid=1 -> new frame presented, out_valid stays 1, no overrun.
